// File: rtl/wordboard.sv
// Switch-programmed serial word transmitter: start, d0..d3 LSB first, stop; idle high.
// Define WORDBOARD_PARITY_EN to insert an even-parity bit between d3 and stop.
module wordboard #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BIT_CYCLES      = 50000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  input  logic sw4,
  input  logic btn_write,
  input  logic btn_auto,
  output logic out
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef WORDBOARD_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Bit order: [3:0] switches sw4..sw1, [4] btn_write, [5] btn_auto.
  logic [5:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] press;

  always_comb begin
    sync1_d = {btn_auto, btn_write, sw4, sw3, sw2, sw1};
    sync2_d = sync1_q;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // press[0] = btn_write, press[1] = btn_auto; one-cycle pulse on debounced rise.
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic          lvl_q, lvl_d, evt_q, evt_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      evt_d = 1'b0;
      if (sync2_q[4+g] != lvl_q) begin
        if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d = ~lvl_q;
          evt_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk) begin
      if (reset) begin
        lvl_q <= 1'b0;
        evt_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl_d;
        evt_q <= evt_d;
        cnt_q <= cnt_d;
      end
    end

    assign press[g] = evt_q;
  end

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    shift_q, shift_d;
  logic          auto_q, auto_d;
  logic          out_q, out_d;
  logic          write_evt, bit_end, launch;
`ifdef WORDBOARD_PARITY_EN
  logic          parity_q, parity_d;
`endif

  always_comb begin
    // A simultaneous auto press wins over a write press.
    write_evt = press[0] & ~press[1];
    auto_d    = auto_q ^ press[1];
    bit_end   = (timer_q == TW'(BIT_CYCLES - 1));
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    launch    = 1'b0;
    timer_d   = (state_q == IDLE || bit_end) ? '0 : timer_q + TW'(1);
`ifdef WORDBOARD_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE:  launch = write_evt | auto_q;
      START: if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
             end
      DATA:  if (bit_end) begin
               if (bit_cnt_q == 2'd3) begin
`ifdef WORDBOARD_PARITY_EN
                 state_d = PARITY;
`else
                 state_d = STOP;
`endif
               end else begin
                 bit_cnt_d = bit_cnt_q + 2'd1;
                 shift_d   = shift_q >> 1;
               end
             end
`ifdef WORDBOARD_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) begin
               state_d = IDLE;
               launch  = auto_q;
             end
      default: state_d = IDLE;
    endcase

    // Word is captured at frame start so mid-frame switch changes wait for the next frame.
    if (launch) begin
      state_d = START;
      shift_d = sync2_q[3:0];
`ifdef WORDBOARD_PARITY_EN
      parity_d = ^sync2_q[3:0];
`endif
    end

    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
`ifdef WORDBOARD_PARITY_EN
      PARITY:  out_d = parity_d;
`endif
      default: out_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      auto_q    <= 1'b0;
      out_q     <= 1'b1;
`ifdef WORDBOARD_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      auto_q    <= auto_d;
      out_q     <= out_d;
`ifdef WORDBOARD_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_wordboard.sv
// Self-checking bench for wordboard with shortened debounce/bit timing and random switch words.
// Honours WORDBOARD_PARITY_EN when the design is built with it.
module tb_wordboard;

  localparam int DB = 8;
  localparam int BC = 20;
`ifdef WORDBOARD_PARITY_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic btn_write = 1'b0, btn_auto = 1'b0;
  logic out;

  int tests_run    = 0;
  int tests_failed = 0;
  int write_hold   = 0;
  int auto_hold    = 0;
  logic [3:0] sw_v = 4'd0;

  wordboard #(.DEBOUNCE_CYCLES(DB), .BIT_CYCLES(BC)) dut (
    .sysclk(sysclk), .reset(reset),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4),
    .btn_write(btn_write), .btn_auto(btn_auto),
    .out(out)
  );

  initial forever #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic drive();
    btn_write = (write_hold > 0);
    btn_auto  = (auto_hold > 0);
    {sw4, sw3, sw2, sw1} = sw_v;
  endtask

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sysclk);
    #1;
    if (write_hold > 0) write_hold--;
    if (auto_hold > 0) auto_hold--;
    drive();
  endtask

  // Expected line level for frame bit position idx carrying word d.
  function automatic logic exp_bit(input logic [3:0] d, input int idx);
    logic [3:0] t;
    if (idx == 0) return 1'b0;
    if (idx <= 4) begin
      t = d >> (idx - 1);
      return t[0];
    end
`ifdef WORDBOARD_PARITY_EN
    if (idx == 5) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, out, 1'b1);
      tick();
    end
  endtask

  // Waits (bounded) for the start bit after a raw press, then checks the latency window.
  task automatic wait_start(input string tag);
    int lat;
    lat = 0;
    while (out !== 1'b0 && lat < DB + 10) begin
      tick();
      lat++;
    end
    check({tag, "_fall"}, out, 1'b0);
    check({tag, "_lat_window"}, (lat >= DB) && (lat <= DB + 5), 1'b1);
  endtask

  // Checks every cycle of one frame starting at the current (start-bit) cycle.
  // act: 1 = press write, 2 = press auto, 3 = new random switch word, at cycle act_at.
  task automatic check_frame(input string tag, input logic [3:0] d, input int act_at, input int act);
    for (int c = 0; c < FL * BC; c++) begin
      check(tag, out, exp_bit(d, c / BC));
      if (c == act_at) begin
        case (act)
          1: write_hold = 2 * DB;
          2: auto_hold  = 2 * DB;
          3: sw_v       = 4'($urandom);
          default: ;
        endcase
        drive();
      end
      tick();
    end
  endtask

  initial begin
    logic [3:0] d;
    int on_c, off_c;

    drive();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_out", out, 1'b1);
    end
    reset = 1'b0;
    idle_check("idle_after_reset", 300);

    // Single frames; a mid-frame write press is dropped, a mid-frame switch change is ignored.
    for (int i = 0; i < 3; i++) begin
      sw_v = (i == 0) ? 4'b1000 : 4'($urandom);
      d = sw_v;
      write_hold = 2 * DB;
      drive();
      wait_start("write");
      check_frame("write_frame", d, 2 * BC, (i == 1) ? 3 : 1);
      idle_check("write_after", 3 * BC);
    end

    // Bounce shorter than the debounce window never produces a frame.
    for (int k = 0; k < 12; k++) begin
      on_c  = $urandom_range(1, DB - 2);
      off_c = $urandom_range(1, DB - 2);
      write_hold = on_c;
      drive();
      for (int j = 0; j < on_c + off_c; j++) begin
        check("bounce_idle", out, 1'b1);
        tick();
      end
    end
    idle_check("bounce_after", 4 * BC);

    // Both buttons at once: auto turns on, frames run back-to-back.
    sw_v = 4'($urandom);
    d = sw_v;
    write_hold = 2 * DB;
    auto_hold  = 2 * DB;
    drive();
    wait_start("auto");
    check_frame("auto_f1", d, 3 * BC, 3);
    d = sw_v;
    check_frame("auto_f2", d, -1, 0);
    check_frame("auto_f3", d, BC, 2);
    idle_check("auto_off_idle", 3 * FL * BC);

    // Reset in the middle of an auto-mode frame abandons it and clears auto.
    sw_v = 4'($urandom);
    d = sw_v;
    auto_hold = 2 * DB;
    drive();
    wait_start("auto2");
    check_frame("auto2_f1", d, -1, 0);
    for (int j = 0; j < BC + 3; j++) tick();
    reset = 1'b1;
    tick();
    check("reset_mid_out", out, 1'b1);
    reset = 1'b0;
    idle_check("reset_mid_idle", 2 * FL * BC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
